uart_rx_os8: RTL and testbench
==============================

Name: uart_rx_os8

Overview:
UART receiver that consumes the 8x-oversampling baud tick (9600 baud × 8 at 100 MHz) and deserialises 8N1 frames from the asynchronous rx pin. It sits directly downstream of the baud tick generator and presents parallel bytes with a one-cycle done strobe to the FIFO/command logic. It detects a start bit, samples each bit at mid-bit, and checks the stop bit.

Parameters:
DATA_BITS, 8, number of data bits per frame, received LSB first.
OS, 8, baud ticks per bit period. Must match the tick generator's oversampling ratio and must be an even number ≥ 4.

Ports:
clk  input  1  system clock, 100 MHz.
rst  input  1  asynchronous reset, active-high.
baud_tick  input  1  one-clk pulse, OS pulses per bit period.
rx  input  1  serial line. Asynchronous to clk; idles high.
rx_data  output  DATA_BITS  last received byte. Holds its value until the next frame completes.
rx_done  output  1  one-clk pulse when rx_data is updated.
rx_busy  output  1  high while the receiver is in any state other than IDLE.
frame_err  output  1  stop-bit status of the last completed frame (1 = stop bit was 0).

Behaviour:
- Reset: rst is asynchronous, active-high; the clock is clk. During reset, rx_data=0, rx_done=0, rx_busy=0, frame_err=0, both synchroniser flops=1, state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0.
- Synchroniser: rx passes through 2 flops (rx_s). All decisions use rx_s only, which adds 2 clk of latency.
- tick_cnt is $clog2(OS) bits wide and bit_cnt is $clog2(DATA_BITS) bits wide. Both counters advance only on clk cycles where baud_tick=1.
- State machine with states IDLE, START, DATA, STOP, WAIT_HIGH:
  - IDLE: rx_busy=0. When rx_s=0 on any clk cycle, go to START with tick_cnt=0. No tick is needed to enter START.
  - START: on each tick, tick_cnt++. At the tick where tick_cnt==OS/2-1 (the 4th tick, mid start bit):
    - if rx_s=0: tick_cnt←0, bit_cnt←0, go to DATA;
    - if rx_s=1: false start; go to IDLE with no outputs changed.
  - DATA: on each tick, tick_cnt++. At the tick where tick_cnt==OS-1:
    - shift register ← {rx_s, shift[DATA_BITS-1:1]} (LSB first);
    - tick_cnt←0;
    - bit_cnt++ ;
    - after the DATA_BITS-th sample, go to STOP.
  - STOP: at the tick where tick_cnt==OS-1, sample rx_s. On the same edge: rx_data←shift register, rx_done←1 (for exactly one clk), frame_err←~rx_s. Next state is IDLE if rx_s=1, or WAIT_HIGH if rx_s=0.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition from retriggering frames.
- rx_done is deasserted on the clk after its pulse. A frame with a framing error still pulses rx_done and updates rx_data.
- Back-to-back frames: returning to IDLE at mid stop bit lets the next falling edge be caught, so no idle gap is required.
- Ticks are ignored in IDLE and WAIT_HIGH.
- rx_s changes between ticks have no effect except in IDLE (start detect) and WAIT_HIGH.
- rst mid-frame: return to IDLE immediately, discard the partial byte, and clear rx_data and frame_err to 0.

Test Plan:
- Bench setup: drive baud_tick every 4 clk; one bit = 32 clk. Send frame 0x55 (rx: 0, 1,0,1,0,1,0,1,0, 1) → one rx_done pulse, rx_data=0x55, frame_err=0, rx_busy low afterward.
- Send 0xA3 immediately followed by 0x3C with no idle bits → two rx_done pulses 320 clk apart; rx_data=0xA3, then 0x3C.
- Glitch rx low for 2 ticks (8 clk), then high → no rx_done, rx_busy returns to 0 by the 4th tick, rx_data unchanged.
- Send 0x81 with stop bit=0, holding rx low for 20 more bit times → rx_done once, rx_data=0x81, frame_err=1, state held in WAIT_HIGH. After rx goes high, send 0x12 → rx_data=0x12, frame_err=0.
- Assert rst during data bit 4 of 0xF0 → all outputs 0 immediately. Then send a full 0x0F frame → rx_data=0x0F.
- Hold baud_tick=0 for 1000 clk during a frame → state and counters freeze and no rx_done occurs. When ticks resume, the byte completes correctly.

Source files
------------

// File: rtl/uart_rx_os8.sv
// 8N1 UART receiver driven by an OS-times oversampling baud tick.
// Bytes are sampled at mid-bit and presented with a one-clk done strobe and stop-bit status.
module uart_rx_os8 #(
    parameter int DATA_BITS = 8,
    parameter int OS        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err
);

    localparam int TW = $clog2(OS);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID = TW'(OS / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    logic                 rx_meta_r;
    logic                 rx_sync_r;
    state_t               state_r;
    state_t               state_s;
    logic [TW-1:0]        tick_cnt_r;
    logic [TW-1:0]        tick_cnt_s;
    logic [BW-1:0]        bit_cnt_r;
    logic [BW-1:0]        bit_cnt_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_s;
    logic [DATA_BITS-1:0] rx_data_s;
    logic                 rx_done_s;
    logic                 frame_err_s;

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            tick_cnt_r <= {TW{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            shift_r    <= {DATA_BITS{1'b0}};
            rx_data    <= {DATA_BITS{1'b0}};
            rx_done    <= 1'b0;
            rx_busy    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_r    <= state_s;
            tick_cnt_r <= tick_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            rx_data    <= rx_data_s;
            rx_done    <= rx_done_s;
            rx_busy    <= (state_s != IDLE);
            frame_err  <= frame_err_s;
        end
    end

    // Next-state and datapath decode; counters only move on baud ticks
    always_comb begin
        state_s     = state_r;
        tick_cnt_s  = tick_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        rx_data_s   = rx_data;
        rx_done_s   = 1'b0;
        frame_err_s = frame_err;
        case (state_r)
            IDLE: begin
                if (!rx_sync_r) begin
                    state_s    = START;
                    tick_cnt_s = {TW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tick_cnt_r == TICK_MID) begin
                        tick_cnt_s = {TW{1'b0}};
                        bit_cnt_s  = {BW{1'b0}};
                        // A line back high at mid start bit was only a glitch
                        state_s    = rx_sync_r ? IDLE : DATA;
                    end else begin
                        tick_cnt_s = tick_cnt_r + 1'b1;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tick_cnt_r == TICK_END) begin
                        shift_s    = {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        tick_cnt_s = {TW{1'b0}};
                        bit_cnt_s  = bit_cnt_r + 1'b1;
                        state_s    = (bit_cnt_r == BIT_LAST) ? STOP : DATA;
                    end else begin
                        tick_cnt_s = tick_cnt_r + 1'b1;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (tick_cnt_r == TICK_END) begin
                        rx_data_s   = shift_r;
                        rx_done_s   = 1'b1;
                        frame_err_s = ~rx_sync_r;
                        tick_cnt_s  = {TW{1'b0}};
                        // Leaving at mid stop bit lets the next start edge be caught
                        state_s     = rx_sync_r ? IDLE : WAIT_HIGH;
                    end else begin
                        tick_cnt_s = tick_cnt_r + 1'b1;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            WAIT_HIGH: begin
                if (rx_sync_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_HIGH;
                end
            end
            default: begin
                state_s    = IDLE;
                tick_cnt_s = {TW{1'b0}};
                bit_cnt_s  = {BW{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_os8.sv
// Scoreboard bench for uart_rx_os8: stimulus pushes expected {frame_err, byte},
// a monitor pops and compares on every rx_done pulse.
module tb_uart_rx_os8;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    int         tests = 0;
    int         fails = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    int         last_done_cyc = 0;
    int         prev_done_cyc = 0;
    logic       tick_en = 1'b1;
    logic [1:0] ph = 2'd0;
    logic [8:0] exp_q[$];

    uart_rx_os8 #(.DATA_BITS(8), .OS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One tick every 4 clk; phase keeps running while ticks are gated off
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            ph = ph + 2'd1;
            baud_tick = tick_en && (ph == 2'd0);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rx_done pulse must match the head of the scoreboard
    initial begin
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rx_done === 1'b1) begin
                done_cnt++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got %0h expected none", {frame_err, rx_data});
                end else begin
                    e = exp_q.pop_front();
                    check("rx_byte", 32'({frame_err, rx_data}), 32'(e));
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Send one frame; bit stretch_bit (if 0..7) is extended by a 1000-clk tick freeze
    task automatic send(input logic [7:0] d, input logic stop_bit, input int stretch_bit);
        rx = 1'b0;
        wait_clk(32);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == stretch_bit) begin
                wait_clk(16);
                tick_en = 1'b0;
                wait_clk(500);
                check("freeze_busy", 32'(rx_busy), 32'd1);
                wait_clk(500);
                tick_en = 1'b1;
                wait_clk(16);
            end else begin
                wait_clk(32);
            end
        end
        rx = stop_bit;
        wait_clk(32);
    endtask

    initial begin
        logic [7:0] f0;
        f0  = 8'hF0;
        rst = 1'b1;
        rx  = 1'b1;
        wait_clk(5);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_done", 32'(rx_done), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b0;
        wait_clk(20);

        // Plain frame
        exp_q.push_back({1'b0, 8'h55});
        send(8'h55, 1'b1, -1);
        wait_clk(8);
        check("busy_after_55", 32'(rx_busy), 32'd0);
        check("cnt_55", 32'(done_cnt), 32'd1);

        // Back-to-back frames with no idle bits
        exp_q.push_back({1'b0, 8'hA3});
        exp_q.push_back({1'b0, 8'h3C});
        send(8'hA3, 1'b1, -1);
        send(8'h3C, 1'b1, -1);
        wait_clk(40);
        check("cnt_b2b", 32'(done_cnt), 32'd3);
        check("b2b_gap", 32'(last_done_cyc - prev_done_cyc), 32'd320);

        // Short glitch: false start
        rx = 1'b0;
        wait_clk(4);
        check("glitch_busy_hi", 32'(rx_busy), 32'd1);
        wait_clk(4);
        rx = 1'b1;
        wait_clk(30);
        check("glitch_busy_lo", 32'(rx_busy), 32'd0);
        check("glitch_cnt", 32'(done_cnt), 32'd3);
        check("glitch_data", 32'(rx_data), 32'h3C);

        // Framing error followed by a long break
        exp_q.push_back({1'b1, 8'h81});
        send(8'h81, 1'b0, -1);
        wait_clk(20 * 32);
        check("break_busy", 32'(rx_busy), 32'd1);
        check("break_cnt", 32'(done_cnt), 32'd4);
        check("break_ferr", 32'(frame_err), 32'd1);
        rx = 1'b1;
        wait_clk(8);
        check("break_release", 32'(rx_busy), 32'd0);
        wait_clk(32);
        exp_q.push_back({1'b0, 8'h12});
        send(8'h12, 1'b1, -1);
        wait_clk(16);
        check("cnt_12", 32'(done_cnt), 32'd5);

        // Reset in the middle of data bit 4 of 0xF0
        rx = 1'b0;
        wait_clk(32);
        for (int i = 0; i < 4; i++) begin
            rx = f0[i];
            wait_clk(32);
        end
        rx = f0[4];
        wait_clk(16);
        rst = 1'b1;
        #1;
        check("midrst_data", 32'(rx_data), 32'd0);
        check("midrst_done", 32'(rx_done), 32'd0);
        check("midrst_busy", 32'(rx_busy), 32'd0);
        check("midrst_ferr", 32'(frame_err), 32'd0);
        wait_clk(2);
        rst = 1'b0;
        rx  = 1'b1;
        wait_clk(100);
        check("midrst_cnt", 32'(done_cnt), 32'd5);
        exp_q.push_back({1'b0, 8'h0F});
        send(8'h0F, 1'b1, -1);
        wait_clk(16);
        check("cnt_0f", 32'(done_cnt), 32'd6);

        // Tick freeze during data bit 3
        exp_q.push_back({1'b0, 8'hC6});
        send(8'hC6, 1'b1, 3);
        wait_clk(16);
        check("cnt_freeze", 32'(done_cnt), 32'd7);

        wait_clk(50);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
